// File: rtl/s_acq_pkg.sv
// rtl/s_acq_pkg.sv - shared state encoding and default widths for the echo-train acquisition scheduler
package s_acq_pkg;

    localparam int S_ACQ_CNT_W = 16;
    localparam int S_ACQ_NUM_W = 12;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEAD = 3'd1,
        ACQ  = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } s_acq_state_t;

endpackage

// File: rtl/s_acq_timer.sv
// rtl/s_acq_timer.sv - loadable down-counter shared by the dead, window and gap phases
module s_acq_timer
    import s_acq_pkg::*;
#(
    parameter int CNT_W = S_ACQ_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (dec) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/s_acq_sched.sv
// rtl/s_acq_sched.sv - echo-train acquisition scheduler driving the sampling-clock divider enable
// Optional per-window sample counter on s_clk is built only when S_ACQ_SAMPLE_CNT_EN is defined.
module s_acq_sched
    import s_acq_pkg::*;
#(
    parameter int CNT_W = S_ACQ_CNT_W,
    parameter int NUM_W = S_ACQ_NUM_W
) (
    input  logic             clk_dds,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] echo_num,
    input  logic [CNT_W-1:0] dead_time,
    input  logic [CNT_W-1:0] acq_len,
    input  logic [CNT_W-1:0] echo_gap,
    input  logic             s_clk,
    output logic             s_acq_en,
    output logic             busy,
    output logic             echo_start,
    output logic [NUM_W-1:0] echo_idx,
    output logic             done,
    output logic             aborted,
    output logic [CNT_W-1:0] sample_cnt
);

    s_acq_state_t     state_q, state_d;
    logic [NUM_W-1:0] echo_num_q, echo_num_d;
    logic [CNT_W-1:0] acq_len_q, acq_len_d;
    logic [CNT_W-1:0] echo_gap_q, echo_gap_d;
    logic [NUM_W-1:0] echo_idx_q, echo_idx_d;
    logic             s_acq_en_q, s_acq_en_d;
    logic             busy_q, busy_d;
    logic             echo_start_q, echo_start_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             tmr_load;
    logic             tmr_dec;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_zero;

    s_acq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk_dds),
        .rst   (rst),
        .load  (tmr_load),
        .dec   (tmr_dec),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        echo_num_d   = echo_num_q;
        acq_len_d    = acq_len_q;
        echo_gap_d   = echo_gap_q;
        echo_idx_d   = echo_idx_q;
        echo_start_d = 1'b0;
        aborted_d    = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        tmr_value    = acq_len_q;

        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && echo_num != '0 && !abort) begin
                        echo_num_d = echo_num;
                        acq_len_d  = acq_len;
                        echo_gap_d = echo_gap;
                        echo_idx_d = '0;
                        tmr_load   = 1'b1;
                        tmr_value  = dead_time;
                        state_d    = DEAD;
                    end
                end
                DEAD: begin
                    if (tmr_zero) begin
                        tmr_load     = 1'b1;
                        echo_start_d = 1'b1;
                        state_d      = ACQ;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                ACQ: begin
                    if (tmr_zero) begin
                        if (echo_idx_q == echo_num_q - NUM_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            tmr_load  = 1'b1;
                            tmr_value = echo_gap_q;
                            state_d   = GAP;
                        end
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                GAP: begin
                    if (tmr_zero) begin
                        echo_idx_d   = echo_idx_q + NUM_W'(1);
                        tmr_load     = 1'b1;
                        echo_start_d = 1'b1;
                        state_d      = ACQ;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with state_q after the edge.
        s_acq_en_d = (state_d == ACQ);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk_dds) begin
        if (rst) begin
            state_q      <= IDLE;
            echo_num_q   <= '0;
            acq_len_q    <= '0;
            echo_gap_q   <= '0;
            echo_idx_q   <= '0;
            s_acq_en_q   <= 1'b0;
            busy_q       <= 1'b0;
            echo_start_q <= 1'b0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            echo_num_q   <= echo_num_d;
            acq_len_q    <= acq_len_d;
            echo_gap_q   <= echo_gap_d;
            echo_idx_q   <= echo_idx_d;
            s_acq_en_q   <= s_acq_en_d;
            busy_q       <= busy_d;
            echo_start_q <= echo_start_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    assign s_acq_en   = s_acq_en_q;
    assign busy       = busy_q;
    assign echo_start = echo_start_q;
    assign echo_idx   = echo_idx_q;
    assign done       = done_q;
    assign aborted    = aborted_q;

`ifdef S_ACQ_SAMPLE_CNT_EN
    logic             s_clk_q;
    logic             s_clk_prev_q;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic             rise_in_acq;

    assign rise_in_acq = s_clk_q && !s_clk_prev_q && (state_q == ACQ);

    always_comb begin
        edge_cnt_d   = edge_cnt_q + CNT_W'(rise_in_acq);
        sample_cnt_d = sample_cnt_q;
        if (echo_start_d) begin
            edge_cnt_d = '0;
        end
        // Snapshot includes an edge landing on the final window cycle.
        if ((state_q == ACQ && state_d != ACQ) || aborted_d) begin
            sample_cnt_d = edge_cnt_q + CNT_W'(rise_in_acq);
        end
    end

    always_ff @(posedge clk_dds) begin
        if (rst) begin
            s_clk_q      <= 1'b0;
            s_clk_prev_q <= 1'b0;
            edge_cnt_q   <= '0;
            sample_cnt_q <= '0;
        end else begin
            s_clk_q      <= s_clk;
            s_clk_prev_q <= s_clk_q;
            edge_cnt_q   <= edge_cnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign sample_cnt = sample_cnt_q;
`else
    logic unused_s_clk;
    assign unused_s_clk = s_clk;
    assign sample_cnt   = '0;
`endif

endmodule

// File: tb/tb_s_acq_sched.sv
// tb/tb_s_acq_sched.sv - self-checking bench for s_acq_sched against a trace-building reference model
module tb_s_acq_sched;

    localparam int CNT_W = 16;
    localparam int NUM_W = 12;

    logic             clk_dds = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NUM_W-1:0] echo_num = '0;
    logic [CNT_W-1:0] dead_time = '0;
    logic [CNT_W-1:0] acq_len = '0;
    logic [CNT_W-1:0] echo_gap = '0;
    logic             s_clk;
    logic             s_acq_en;
    logic             busy;
    logic             echo_start;
    logic [NUM_W-1:0] echo_idx;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] sample_cnt;
    logic [1:0]       div_q = 2'd0;

    s_acq_sched #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W)
    ) dut (
        .clk_dds    (clk_dds),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .echo_num   (echo_num),
        .dead_time  (dead_time),
        .acq_len    (acq_len),
        .echo_gap   (echo_gap),
        .s_clk      (s_clk),
        .s_acq_en   (s_acq_en),
        .busy       (busy),
        .echo_start (echo_start),
        .echo_idx   (echo_idx),
        .done       (done),
        .aborted    (aborted),
        .sample_cnt (sample_cnt)
    );

    always #5 clk_dds = ~clk_dds;

    // Free-running divide-by-4 sample clock.
    always @(posedge clk_dds) div_q <= div_q + 2'd1;
    assign s_clk = div_q[1];

    typedef struct {
        bit busy;
        bit en;
        bit es;
        int idx;
        bit done;
        bit ab;
    } exp_t;

    exp_t q[$];
    exp_t exp_cur;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 0;
    bit   sc_mode = 0;
    bit   prev_en = 0;
    int   cyc = 0;
    int   first_en, done_at, ab_at, en_cnt;

    task automatic check(input string tag, input longint got, input longint expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    function automatic exp_t mk(bit b, bit e, bit s, int i, bit d, bit a);
        exp_t x;
        x.busy = b; x.en = e; x.es = s; x.idx = i; x.done = d; x.ab = a;
        return x;
    endfunction

    // Expected per-cycle trace of a whole train, derived from the phase durations.
    task automatic build(input int n, input int d, input int a, input int g);
        q.delete();
        for (int i = 0; i <= d; i++) q.push_back(mk(1, 0, 0, 0, 0, 0));
        for (int e = 0; e < n; e++) begin
            for (int k = 0; k <= a; k++) q.push_back(mk(1, 1, k == 0, e, 0, 0));
            if (e < n - 1)
                for (int k = 0; k <= g; k++) q.push_back(mk(1, 0, 0, e, 0, 0));
        end
        q.push_back(mk(1, 0, 0, n - 1, 1, 0));
    endtask

    task automatic clear_obs();
        first_en = -1; done_at = -1; ab_at = -1; en_cnt = 0;
    endtask

    task automatic step(input bit r, input bit s, input bit ab,
                        input int n, input int d, input int a, input int g);
        exp_t nxt;
        @(negedge clk_dds);
        if (chk_en) begin
            check("busy", busy, exp_cur.busy);
            check("s_acq_en", s_acq_en, exp_cur.en);
            check("echo_start", echo_start, exp_cur.es);
            check("echo_idx", echo_idx, exp_cur.idx);
            check("done", done, exp_cur.done);
            check("aborted", aborted, exp_cur.ab);
`ifdef S_ACQ_SAMPLE_CNT_EN
            if (sc_mode && prev_en && !exp_cur.en) check("sample_cnt", sample_cnt, 4);
`else
            check("sample_cnt", sample_cnt, 0);
`endif
            prev_en = exp_cur.en;
            if (s_acq_en) en_cnt++;
            if (s_acq_en && first_en < 0) first_en = cyc;
            if (done) done_at = cyc;
            if (aborted) ab_at = cyc;
        end
        rst = r; start = s; abort = ab;
        echo_num = NUM_W'(n); dead_time = CNT_W'(d); acq_len = CNT_W'(a); echo_gap = CNT_W'(g);
        if (r) begin
            q.delete();
            nxt = mk(0, 0, 0, 0, 0, 0);
        end else if (exp_cur.busy && ab) begin
            q.delete();
            nxt = mk(0, 0, 0, exp_cur.idx, 0, 1);
        end else if (!exp_cur.busy && s && n != 0 && !ab) begin
            build(n, d, a, g);
            nxt = q.pop_front();
        end else if (q.size() > 0) begin
            nxt = q.pop_front();
        end else begin
            nxt = mk(0, 0, 0, exp_cur.idx, 0, 0);
        end
        @(posedge clk_dds);
        cyc++;
        exp_cur = nxt;
        chk_en = chk_en | r;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++)
            step(0, 0, 0, $urandom_range(0, 4), $urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        exp_cur = mk(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle_cycles(3);

        // Nominal train with an ignored second start mid-train.
        clear_obs();
        t0 = cyc;
        step(0, 1, 0, 3, 4, 7, 2);
        for (int i = 1; i <= 40; i++)
            step(0, i == 15, 0, 2, 9, 1, 1);
        check("nom_first_en", first_en, t0 + 6);
        check("nom_done", done_at, t0 + 36);
        check("nom_en_cycles", en_cnt, 24);

        // All durations zero, single echo.
        clear_obs();
        t0 = cyc;
        step(0, 1, 0, 1, 0, 0, 0);
        idle_cycles(6);
        check("zero_first_en", first_en, t0 + 2);
        check("zero_en_cycles", en_cnt, 1);
        check("zero_done", done_at, t0 + 3);

        // Zero echo count is ignored.
        clear_obs();
        step(0, 1, 0, 0, 3, 3, 3);
        idle_cycles(6);
        check("num0_done", done_at, -1);
        check("num0_en_cycles", en_cnt, 0);

        // Abort in the gap after echo 1, then restart right after the aborted pulse.
        clear_obs();
        t0 = cyc;
        step(0, 1, 0, 3, 2, 3, 4);
        for (int i = 1; i <= 18; i++) step(0, 0, i == 18, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("abort_pulse", ab_at, t0 + 19);
        check("abort_no_done", done_at, -1);
        t0 = cyc;
        step(0, 1, 0, 1, 1, 1, 1);
        idle_cycles(8);
        check("restart_done", done_at, t0 + 5);

        // Start and abort together in IDLE.
        clear_obs();
        step(0, 1, 1, 2, 1, 1, 1);
        idle_cycles(8);
        check("collide_en_cycles", en_cnt, 0);
        check("collide_done", done_at, -1);

        // Reset mid-window.
        clear_obs();
        step(0, 1, 0, 2, 1, 5, 1);
        for (int i = 1; i <= 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        idle_cycles(8);
        check("rst_no_done", done_at, -1);
        check("rst_no_abort", ab_at, -1);

        // Sample counting over 16-cycle windows.
        sc_mode = 1;
        prev_en = 0;
        step(0, 1, 0, 2, 0, 15, 3);
        idle_cycles(45);
        sc_mode = 0;

        // Randomized traffic with mid-train configuration churn.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 599) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 4), $urandom_range(0, 5),
                 $urandom_range(0, 5), $urandom_range(0, 5));
        end
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/s_acq_sched.md
# s_acq_sched

Echo-train acquisition scheduler for the sampling clock path. On a start pulse it waits a programmable dead time, then opens a train of acquisition windows (one per echo) separated by programmable gaps. For each window it drives `s_acq_en` into the DDS sampling-clock divider, which produces the ADC sample clock only while enabled. It sits between the pulse-sequence controller (start/abort/configuration) and the divider, and reports progress and completion back to the sequence controller.

## Interface
- `CNT_W`, 16, width of the dead/acq/gap duration fields, in `clk_dds` cycles
- `NUM_W`, 12, width of the echo count and echo index

- `clk_dds`  in  1  DDS clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin an echo train
- `abort`  in  1  one-cycle request to terminate the train immediately
- `echo_num`  in  NUM_W  number of echoes; 0 means the start is ignored
- `dead_time`  in  CNT_W  pre-train delay; lasts dead_time+1 cycles
- `acq_len`  in  CNT_W  window length; lasts acq_len+1 cycles
- `echo_gap`  in  CNT_W  inter-window gap; lasts echo_gap+1 cycles
- `s_clk`  in  1  divided sample clock fed back from the divider (used only with the macro)
- `s_acq_en`  out  1  divider enable, registered
- `busy`  out  1  high in every state except IDLE
- `echo_start`  out  1  pulse on the first ACQ cycle of each echo
- `echo_idx`  out  NUM_W  0-based index of the current or last echo
- `done`  out  1  one-cycle pulse on normal completion
- `aborted`  out  1  one-cycle pulse on abort
- `sample_cnt`  out  CNT_W  samples in the last completed window (macro only)

## Operation
- States: IDLE, DEAD, ACQ, GAP, DONE.
- **IDLE**: `start` && `echo_num`!=0 && !`abort` does the following:
  - latches `echo_num`, `dead_time`, `acq_len` and `echo_gap`;
  - loads the counter with `dead_time`;
  - clears `echo_idx`;
  - moves to DEAD.
- Inputs are not sampled again until the next IDLE, so configuration changes mid-train have no effect.
- **DEAD**: the counter decrements each cycle. At counter==0 the block loads `acq_len` and moves to ACQ.
- **ACQ**: `s_acq_en`=1 and the counter decrements. At counter==0:
  - if `echo_idx`==latched `echo_num`-1, go to DONE;
  - otherwise load `echo_gap` and go to GAP.
- **GAP**: the counter decrements. At counter==0 the block increments `echo_idx`, loads `acq_len` and moves to ACQ.
- **DONE**: `done`=1 for one cycle, then IDLE. `echo_idx` holds its last value.
- `start` outside IDLE is ignored.
- `abort` in any non-IDLE state:
  - next state is IDLE, with `s_acq_en`=0 and `aborted`=1 on that next cycle;
  - `done` is not asserted.
- `abort` in IDLE is ignored. `abort` and `start` in the same cycle in IDLE: the abort wins and nothing starts.
- `rst` forces IDLE and drives every output and the counter to 0. This applies mid-train too; no `done` or `aborted` pulse is produced.

## Timing
- `start` is accepted at edge T. DEAD occupies cycles T+1 .. T+1+`dead_time`.
- The first ACQ cycle, with `s_acq_en`=1 and `echo_start`=1, is T+2+`dead_time`.
- Every output is registered and reflects the current state, with no combinational input-to-output path.
- Total `busy` time: (`dead_time`+1) + N·(`acq_len`+1) + (N−1)·(`echo_gap`+1) + 1 cycles, where N is `echo_num`.
- `echo_idx` changes on the first ACQ cycle of each echo after the first.
- `s_acq_en` falls on the cycle after the last ACQ cycle. The divider then resets its output low, because its enable is gone.

## Configuration
- `S_ACQ_SAMPLE_CNT_EN` defined:
  - `s_clk` is registered once and rising edges are detected in the `clk_dds` domain;
  - edges are counted only during ACQ;
  - the count is cleared at `echo_start`;
  - the count is copied to `sample_cnt` on the cycle after each window ends, and on abort.
- `S_ACQ_SAMPLE_CNT_EN` not defined: `sample_cnt` is tied to 0, `s_clk` is unused, and no counter logic is built.

## Structure
- Shared package `s_acq_pkg`:
  - state enum `s_acq_state_t` (IDLE=0, DEAD=1, ACQ=2, GAP=3, DONE=4);
  - default widths `S_ACQ_CNT_W`=16 and `S_ACQ_NUM_W`=12.
- One sub-module, `s_acq_timer`:
  - CNT_W-wide loadable down-counter with a `load`/`value` interface;
  - `zero` output, combinational from the count;
  - instantiated once and shared across the DEAD, ACQ and GAP phases.

## Test plan
- **Nominal train**: `echo_num`=3, `dead_time`=4, `acq_len`=7, `echo_gap`=2, start at T.
  - First `s_acq_en` at T+6.
  - Three 8-cycle windows separated by 3-cycle gaps.
  - `echo_idx` steps 0,1,2.
  - `done` at T+36, `busy` low at T+37.
- **Zero durations**: `echo_num`=1, all durations 0, start at T.
  - `s_acq_en` is high for exactly cycle T+2.
  - `done` at T+3.
- **Ignored requests**:
  - `echo_num`=0 with start: `busy` stays 0 and no `done`.
  - A second start mid-train: the timing is unchanged.
- **Abort in GAP of echo 1**: `s_acq_en`=0 and `aborted`=1 on the next cycle, `done` never pulses.
  - A start in the cycle after the `aborted` pulse is accepted normally.
- **Reset and start/abort collision**:
  - Simultaneous start and abort in IDLE: nothing starts.
  - `rst` during ACQ: all outputs are 0 on the next cycle.
- **Sample count (`S_ACQ_SAMPLE_CNT_EN`)**:
  - `acq_len`=15 with a /4 divider model on `s_clk`: `sample_cnt`=4 after each window.
  - Without the macro: `sample_cnt`=0 throughout.
